// File: rtl/dmem_responder_if.sv
// Bus bundle between the processor/host initiators and the data-memory responder.
// Handshake: the host raises Host_Req with Host_Wr/Host_Addr/Host_Wdata stable and
// keeps it high until it sees the one-cycle Host_Ack pulse, then drops it in that
// same Ack cycle; the processor port has no handshake and is never stalled.
interface dmem_responder_if #(
    parameter int CNT_W = 16
);
    logic [0:7]       Mem_Addr;
    logic [0:63]      Data_Out;
    logic             DmemEn;
    logic             DmemWrEn;
    logic [0:63]      Data_In;
    logic             Host_Req;
    logic             Host_Wr;
    logic [0:7]       Host_Addr;
    logic [0:63]      Host_Wdata;
    logic             Host_Ack;
    logic [0:63]      Host_Rdata;
    logic [0:CNT_W-1] Rd_Count;
    logic [0:CNT_W-1] Wr_Count;

    modport slave (
        input  Mem_Addr, Data_Out, DmemEn, DmemWrEn,
        input  Host_Req, Host_Wr, Host_Addr, Host_Wdata,
        output Data_In, Host_Ack, Host_Rdata, Rd_Count, Wr_Count
    );

    modport master (
        output Mem_Addr, Data_Out, DmemEn, DmemWrEn,
        output Host_Req, Host_Wr, Host_Addr, Host_Wdata,
        input  Data_In, Host_Ack, Host_Rdata, Rd_Count, Wr_Count
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single-ported 64-bit word store serving the processor
// load/store port with absolute priority, plus a host preload/dump port that only
// touches the array on edges where the processor is idle.
module dmem_responder #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    dmem_responder_if.slave  bus,
    output logic [1:0]       o_fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    logic [0:63]      r_mem [0:DEPTH-1];
    state_t           r_state;
    logic             r_ack;
    logic [0:63]      r_rdata;
    logic [0:CNT_W-1] r_rd_count;
    logic [0:CNT_W-1] r_wr_count;

    logic             w_proc_rd;
    logic             w_proc_wr;
    logic             w_host_access;
    logic             w_host_wr;
    logic             w_host_rd;

    // Decode which port owns the array at the coming edge.
    always_comb begin
        w_proc_rd     = bus.DmemEn & ~bus.DmemWrEn;
        w_proc_wr     = bus.DmemEn &  bus.DmemWrEn;
        w_host_access = bus.Host_Req & ~bus.DmemEn &
                        ((r_state == S_IDLE) | (r_state == S_WAIT));
        w_host_wr     = w_host_access &  bus.Host_Wr;
        w_host_rd     = w_host_access & ~bus.Host_Wr;
    end

    // Combinational processor load data; zero whenever no load is in progress.
    always_comb begin
        bus.Data_In = '0;
        if (w_proc_rd) begin
            bus.Data_In = r_mem[bus.Mem_Addr];
        end
    end

    // Array write port; contents survive reset but no write lands on a reset edge.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (w_proc_wr) begin
                r_mem[bus.Mem_Addr] <= bus.Data_Out;
            end else if (w_host_wr) begin
                r_mem[bus.Host_Addr] <= bus.Host_Wdata;
            end
        end
    end

    // Host FSM: retry while the processor is busy, then pulse Ack for one cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Host_Req) begin
                        if (!bus.DmemEn) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.Host_Req) begin
                        r_state <= S_IDLE;
                    end else if (!bus.DmemEn) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_host_rd) begin
                r_rdata <= r_mem[bus.Host_Addr];
            end
        end
    end

    // Saturating processor access counters; host traffic is not counted.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_proc_rd && (r_rd_count != '1)) begin
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
            if (w_proc_wr && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end
    end

    assign bus.Host_Ack   = r_ack;
    assign bus.Host_Rdata = r_rdata;
    assign bus.Rd_Count   = r_rd_count;
    assign bus.Wr_Count   = r_wr_count;
    assign o_fsm_state    = r_state;

endmodule
